lsq_free_list: RTL

- Parametrised circular free-list of load/store queue slot IDs.
- Hands one free slot ID per cycle to dispatch and takes back up to two retired IDs per cycle (load retire and store retire).
- Supersedes the fixed 3-entry index queue: generic width and depth, a parametrised initial fill, an occupancy counter, and dual release with overflow/underflow detection.
- Flush restores the post-reset fill.

---
 rtl/lsq_free_list.sv | 112 +++++++++++
 1 files changed

// File: rtl/lsq_free_list.sv
// rtl/lsq_free_list.sv - circular free-list of load/store queue slot IDs
module lsq_free_list #(
    parameter int IDW         = 4,
    parameter int DEPTH       = 4,
    parameter int INIT_COUNT  = 3,
    parameter int INIT_BASE   = 0,
    parameter int INIT_STRIDE = 4
) (
    input  logic                         Clk,
    input  logic                         Rest,
    input  logic                         AllocReq,
    output logic                         AllocGnt,
    output logic [IDW-1:0]               AllocId,
    output logic [IDW-1:0]               AllocPre,
    input  logic                         Rel0Vld,
    input  logic [IDW-1:0]               Rel0Id,
    input  logic                         Rel1Vld,
    input  logic [IDW-1:0]               Rel1Id,
    input  logic                         Flush,
    output logic [$clog2(DEPTH+1)-1:0]   Count,
    output logic                         Full,
    output logic                         Empty,
    output logic                         Overflow,
    output logic                         Underflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [IDW-1:0] entry [DEPTH];
    logic [PW-1:0]  head;
    logic [PW-1:0]  tail;

    logic [CW-1:0]  space;
    logic           grant;
    logic           acc0;
    logic           acc1;
    logic [PW-1:0]  tail1;
    logic [PW-1:0]  tail2;
    logic [PW-1:0]  wr1_ptr;
    logic [PW-1:0]  tail_next;
    logic [CW-1:0]  count_next;
    logic           overflow_hit;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    function automatic logic [IDW-1:0] init_val(input int i);
        return (i < INIT_COUNT) ? IDW'(INIT_BASE + i * INIT_STRIDE) : '0;
    endfunction

    assign Full     = (Count == CW'(DEPTH));
    assign Empty    = (Count == '0);
    assign AllocPre = entry[head];

    // Space is judged on the start-of-cycle count; a same-cycle grant frees nothing yet.
    always_comb begin
        space        = CW'(DEPTH) - Count;
        grant        = AllocReq && !Empty;
        acc0         = Rel0Vld && (space != '0);
        acc1         = Rel1Vld && (acc0 ? (space > CW'(1)) : (space != '0));
        tail1        = ptr_inc(tail);
        tail2        = ptr_inc(tail1);
        wr1_ptr      = acc0 ? tail1 : tail;
        tail_next    = tail;
        if (acc0 && acc1)
            tail_next = tail2;
        else if (acc0 || acc1)
            tail_next = tail1;
        count_next   = Count - CW'(grant) + CW'(acc0) + CW'(acc1);
        overflow_hit = (Rel0Vld && !acc0) || (Rel1Vld && !acc1);
    end

    always_ff @(posedge Clk) begin
        if (!Rest || Flush) begin
            for (int i = 0; i < DEPTH; i++)
                entry[i] <= init_val(i);
            head     <= '0;
            tail     <= PW'(INIT_COUNT % DEPTH);
            Count    <= CW'(INIT_COUNT);
            AllocGnt <= 1'b0;
            AllocId  <= '0;
        end else begin
            if (acc0)
                entry[tail] <= Rel0Id;
            if (acc1)
                entry[wr1_ptr] <= Rel1Id;
            if (grant) begin
                AllocId <= entry[head];
                head    <= ptr_inc(head);
            end
            AllocGnt <= grant;
            tail     <= tail_next;
            Count    <= count_next;
        end
    end

    // Sticky error flags survive Flush; only reset clears them.
    always_ff @(posedge Clk) begin
        if (!Rest) begin
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
        end else if (!Flush) begin
            if (overflow_hit)
                Overflow <= 1'b1;
            if (AllocReq && Empty)
                Underflow <= 1'b1;
        end
    end

endmodule
